// File: rtl/playseq_condicionador_botoes.sv
// Button conditioner for PlaySeq: synchronizes and debounces four raw buttons into a
// one-hot-or-zero vector, with one-cycle press/release pulses and a multi-press error level.
module playseq_condicionador_botoes #(
  parameter int DEBOUNCE_CICLOS = 20,
  parameter int CNT_BITS        = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_brutos,
  input  logic       habilita,
  output logic [3:0] botoes,
  output logic       jogada_pulso,
  output logic       solto_pulso,
  output logic       erro_multiplo,
  output logic [2:0] db_estado
);

  localparam logic [CNT_BITS-1:0] C_CNT_FIM  = CNT_BITS'(DEBOUNCE_CICLOS - 1);
  localparam logic [CNT_BITS-1:0] C_CNT_ZERO = CNT_BITS'(0);
  localparam logic [CNT_BITS-1:0] C_CNT_UM   = CNT_BITS'(1);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA_PRESS = 3'd1,
    PRESSIONADO  = 3'd2,
    FILTRA_SOLTA = 3'd3,
    MULTIPLO     = 3'd4
  } estado_t;

  function automatic logic [2:0] f_popcount(input logic [3:0] v);
    f_popcount = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic f_um_quente(input logic [3:0] v);
    f_um_quente = (f_popcount(v) == 3'd1);
  endfunction

  function automatic logic f_multiplo(input logic [3:0] v);
    f_multiplo = (f_popcount(v) >= 3'd2);
  endfunction

  logic [3:0]          r_s1;
  logic [3:0]          r_s2;
  estado_t             r_estado;
  logic [3:0]          r_cand;
  logic [CNT_BITS-1:0] r_cnt;
  logic [3:0]          r_botoes;
  logic                r_jogada;
  logic                r_solto;
  logic                r_erro;

  estado_t             w_prox_estado;
  logic [3:0]          w_prox_cand;
  logic [CNT_BITS-1:0] w_prox_cnt;
  logic [3:0]          w_prox_botoes;
  logic                w_jogada;
  logic                w_solto;
  logic                w_erro;

  // Two-stage synchronizer for the asynchronous pin levels.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 4'b0000;
      r_s2 <= 4'b0000;
    end else begin
      r_s1 <= botoes_brutos;
      r_s2 <= r_s1;
    end
  end

  // FSM state, candidate, filter counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_cand   <= 4'b0000;
      r_cnt    <= C_CNT_ZERO;
      r_botoes <= 4'b0000;
      r_jogada <= 1'b0;
      r_solto  <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_estado <= w_prox_estado;
      r_cand   <= w_prox_cand;
      r_cnt    <= w_prox_cnt;
      r_botoes <= w_prox_botoes;
      r_jogada <= w_jogada;
      r_solto  <= w_solto;
      r_erro   <= w_erro;
    end
  end

  // Next-state logic; the counter restarts on every state entry and stability break.
  always_comb begin
    w_prox_estado = r_estado;
    w_prox_cand   = r_cand;
    w_prox_cnt    = r_cnt;
    w_jogada      = 1'b0;
    w_solto       = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (habilita && f_um_quente(r_s2)) begin
          w_prox_estado = FILTRA_PRESS;
          w_prox_cand   = r_s2;
          w_prox_cnt    = C_CNT_ZERO;
        end else if (habilita && f_multiplo(r_s2)) begin
          w_prox_estado = MULTIPLO;
          w_prox_cnt    = C_CNT_ZERO;
        end else begin
          w_prox_cnt    = C_CNT_ZERO;
        end
      end
      FILTRA_PRESS: begin
        if (habilita && (r_s2 == r_cand)) begin
          if (r_cnt == C_CNT_FIM) begin
            w_prox_estado = PRESSIONADO;
            w_prox_cnt    = C_CNT_ZERO;
            w_jogada      = 1'b1;
          end else begin
            w_prox_cnt    = r_cnt + C_CNT_UM;
          end
        end else if (f_multiplo(r_s2)) begin
          w_prox_estado = MULTIPLO;
          w_prox_cnt    = C_CNT_ZERO;
        end else begin
          w_prox_estado = OCIOSO;
          w_prox_cnt    = C_CNT_ZERO;
        end
      end
      PRESSIONADO: begin
        // Extra buttons and habilita are ignored; only losing the candidate matters.
        if ((r_s2 & r_cand) == 4'b0000) begin
          w_prox_estado = FILTRA_SOLTA;
          w_prox_cnt    = C_CNT_ZERO;
        end else begin
          w_prox_cnt    = C_CNT_ZERO;
        end
      end
      FILTRA_SOLTA: begin
        if ((r_s2 & r_cand) != 4'b0000) begin
          w_prox_estado = PRESSIONADO;
          w_prox_cnt    = C_CNT_ZERO;
        end else if (r_cnt == C_CNT_FIM) begin
          w_prox_estado = OCIOSO;
          w_prox_cnt    = C_CNT_ZERO;
          w_solto       = 1'b1;
        end else begin
          w_prox_cnt    = r_cnt + C_CNT_UM;
        end
      end
      MULTIPLO: begin
        if (r_s2 != 4'b0000) begin
          w_prox_cnt    = C_CNT_ZERO;
        end else if (r_cnt == C_CNT_FIM) begin
          w_prox_estado = OCIOSO;
          w_prox_cnt    = C_CNT_ZERO;
        end else begin
          w_prox_cnt    = r_cnt + C_CNT_UM;
        end
      end
      default: begin
        w_prox_estado = OCIOSO;
        w_prox_cand   = 4'b0000;
        w_prox_cnt    = C_CNT_ZERO;
      end
    endcase
  end

  // Output values as a function of the state being entered.
  always_comb begin
    w_prox_botoes = 4'b0000;
    w_erro        = 1'b0;
    case (w_prox_estado)
      PRESSIONADO, FILTRA_SOLTA: begin
        w_prox_botoes = w_prox_cand;
      end
      MULTIPLO: begin
        w_erro        = 1'b1;
      end
      default: begin
        w_prox_botoes = 4'b0000;
        w_erro        = 1'b0;
      end
    endcase
  end

  assign botoes        = r_botoes;
  assign jogada_pulso  = r_jogada;
  assign solto_pulso   = r_solto;
  assign erro_multiplo = r_erro;
  assign db_estado     = r_estado;

endmodule
